sinalizador_led_buzzer: RTL
===========================

Name: sinalizador_led_buzzer

Overview:
Parametrised RGB-LED and buzzer indicator controller, successor to the combinational LED/buzzer driver. It accepts indication events over a valid/ready handshake and latches an LED mode: off, steady, or blinking with a configurable period. It also plays a programmable number of timed beeps on an active-low buzzer. It sits between the game/control FSM and the board LEDs and buzzer.

Parameters:
BLINK_DIV, 25000000, clock cycles per blink half-period (≥2)
BEEP_ON_CYC, 12500000, cycles buzzer is active per beep (≥1)
BEEP_OFF_CYC, 12500000, cycles of silence between beeps (≥1)
BEEP_W, 4, width of beep-count field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
evt_valid  in  1  event request
evt_ready  out  1  event can be accepted this cycle
evt_mode  in  3  LED mode: 0 off, 1 green steady, 2 red blink, 3 red+green steady, 4 blue steady, 5 blue blink, 6-7 treated as 0
evt_beeps  in  BEEP_W  number of beeps, 0 = silent
cancel  in  1  abort beep sequence; LED mode is retained
led_vermelho  out  1  red LED, active-high
led_verde  out  1  green LED, active-high
led_azul  out  1  blue LED, active-high
buzzer  out  1  buzzer drive, active-low (1 = silent)
busy  out  1  beep sequence in progress

Behaviour:
- Reset (async assert, sync release): mode=0, all LEDs 0, buzzer=1, busy=0, beep FSM IDLE, blink counter=0, blink phase=1.
- All outputs except evt_ready are registered. evt_ready = (state==IDLE) && !cancel, combinational.
- Accept = evt_valid && evt_ready, sampled at rising edge k. Mode is latched at edge k. The blink counter is cleared and phase set to 1 at edge k. New LED values are visible from edge k.
- Blink: the counter counts 0..BLINK_DIV-1. At the wrap, phase toggles and the counter returns to 0. The counter is free-running otherwise. Blink modes drive the LED = phase. Steady modes ignore phase.
- Beep FSM states: IDLE, ON, OFF. It has a timer (width clog2 of the max of ON/OFF cycles) and a remaining-beep counter rem (BEEP_W bits).
  - IDLE: on accept with evt_beeps≠0: rem←evt_beeps, timer←0, go to ON, buzzer←0 at edge k. If evt_beeps=0, stay in IDLE.
  - ON: timer increments. At timer==BEEP_ON_CYC-1: buzzer←1. If rem==1, go to IDLE. Otherwise rem←rem-1, timer←0, go to OFF.
  - OFF: at timer==BEEP_OFF_CYC-1: timer←0, buzzer←0, go to ON.
  - The buzzer is low for exactly BEEP_ON_CYC cycles per beep. There is no trailing OFF after the last beep.
- busy = (state≠IDLE), registered consistent with the state.
- cancel has priority in every state. Next edge: state IDLE, buzzer=1, timer=0, rem=0. LED mode and blink are untouched. cancel together with evt_valid: event not accepted, since evt_ready=0.
- evt_valid while busy: ignored. evt_ready=0, so the requester must hold valid until accepted.
- Max beeps = 2^BEEP_W-1. No wrap-around, because rem never decrements below 1.
- Reset asserted mid-sequence: buzzer returns to 1 immediately (async), all state cleared.

Test Plan:
1. BLINK_DIV=4, BEEP_ON_CYC=3, BEEP_OFF_CYC=2. Release reset, idle 10 cycles -> LEDs 000, buzzer=1, busy=0, evt_ready=1.
2. Accept mode=2, beeps=0 -> led_vermelho high 4 cycles, low 4, repeating; green/blue 0; buzzer stays 1; evt_ready stays 1.
3. Accept mode=1, beeps=3 -> green steady. buzzer pattern from edge k: 0,0,0,1,1,0,0,0,1,1,0,0,0 then 1. busy high 13 cycles. evt_ready low throughout.
4. During test 3, pulse evt_valid mode=4 while busy -> not accepted, green remains. Hold valid: accepted in the first cycle after busy falls, and blue turns on.
5. Accept beeps=5, assert cancel in the 2nd ON phase with evt_valid also high -> buzzer=1 next edge, busy=0, event not accepted that cycle, LED mode unchanged.
6. Accept mode=5, beeps=15, then assert rst_n=0 mid-beep -> buzzer=1 and all LEDs 0 without a clock edge. After release, state is as in test 1.

Source files
------------

// File: rtl/sinalizador_led_buzzer_if.sv
// rtl/sinalizador_led_buzzer_if.sv - indication event handshake between the control FSM and the LED/buzzer controller
interface sinalizador_led_buzzer_if #(
  parameter int BEEP_W = 4
);
  logic              evt_valid;
  logic              evt_ready;
  logic [2:0]        evt_mode;
  logic [BEEP_W-1:0] evt_beeps;

  modport master (output evt_valid, output evt_mode, output evt_beeps, input evt_ready);
  modport slave  (input evt_valid, input evt_mode, input evt_beeps, output evt_ready);
endinterface

// File: rtl/sinalizador_led_buzzer.sv
// rtl/sinalizador_led_buzzer.sv - RGB LED mode latch with blink generator and active-low beep sequencer
module sinalizador_led_buzzer #(
  parameter int BLINK_DIV    = 25000000,
  parameter int BEEP_ON_CYC  = 12500000,
  parameter int BEEP_OFF_CYC = 12500000,
  parameter int BEEP_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sinalizador_led_buzzer_if.slave   evt,
  input  logic                      cancel,
  output logic                      led_vermelho,
  output logic                      led_verde,
  output logic                      led_azul,
  output logic                      buzzer,
  output logic                      busy
);

  localparam int MAXC = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int CW   = $clog2(BLINK_DIV);

  localparam logic [TW-1:0] ON_LAST    = TW'(BEEP_ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(BEEP_OFF_CYC - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BEEP_W-1:0] rem_q, rem_d;
  logic [2:0]        mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              buzz_q, buzz_d;
  logic              busy_q, busy_d;
  logic [2:0]        led_q, led_d;
  logic              accept;

  assign evt.evt_ready = (state_q == ST_IDLE) && !cancel;
  assign accept        = evt.evt_valid && evt.evt_ready;

  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (accept) begin
      mode_d  = evt.evt_mode;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == BLINK_LAST) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // LEDs are registered from next-state mode/phase so a new mode shows at the accepting edge
    led_d = 3'b000;  // {red, green, blue}
    case (mode_d)
      3'd1:    led_d = 3'b010;
      3'd2:    led_d = {phase_d, 2'b00};
      3'd3:    led_d = 3'b110;
      3'd4:    led_d = 3'b001;
      3'd5:    led_d = {2'b00, phase_d};
      default: led_d = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    buzz_d  = buzz_q;
    if (cancel) begin
      state_d = ST_IDLE;
      timer_d = '0;
      rem_d   = '0;
      buzz_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (evt.evt_beeps != '0)) begin
            rem_d   = evt.evt_beeps;
            timer_d = '0;
            state_d = ST_ON;
            buzz_d  = 1'b0;
          end
        end
        ST_ON: begin
          if (timer_q == ON_LAST) begin
            buzz_d  = 1'b1;
            timer_d = '0;
            // the last beep ends straight in IDLE, with no trailing silence
            if (rem_q == 1) begin
              state_d = ST_IDLE;
            end else begin
              rem_d   = rem_q - 1'b1;
              state_d = ST_OFF;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_OFF: begin
          if (timer_q == OFF_LAST) begin
            timer_d = '0;
            buzz_d  = 1'b0;
            state_d = ST_ON;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
          rem_d   = '0;
          buzz_d  = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      mode_q  <= 3'd0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      buzz_q  <= 1'b1;
      busy_q  <= 1'b0;
      led_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      buzz_q  <= buzz_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign led_vermelho = led_q[2];
  assign led_verde    = led_q[1];
  assign led_azul     = led_q[0];
  assign buzzer       = buzz_q;
  assign busy         = busy_q;

endmodule
